// File: rtl/fp4_array_sequencer.sv
// Host-side sequencer for the fp4 x int8 systolic array: buffers K-step groups, replays them phase-aligned,
// pulses read-out, then captures the W*H result bytes into a FIFO and returns them on a valid/ready stream.

// Result FIFO: one-entry-per-cycle write, registered read side; data appears one cycle after the write.
// A write into a full FIFO is dropped; the read side obeys i_rd_rdy.
module fp4_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_vld,
  input  logic [W-1:0] i_wr_dat,
  output logic         o_rd_vld,
  output logic [W-1:0] o_rd_dat,
  input  logic         i_rd_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_rd_vld = (r_cnt != '0);
  // Gate the read data so the output is a clean zero while empty.
  assign o_rd_dat = o_rd_vld ? r_mem[r_rd_ptr] : '0;
  assign w_push   = i_wr_vld && (r_cnt != CNT_FULL);
  assign w_pop    = o_rd_vld && i_rd_rdy;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// Sequencer top: group emission is phase-locked to the array slice counter; results return R+2 onward.
// Host input stalls only while a group waits or emits; the array side is never stalled.
module fp4_array_sequencer #(
  parameter int SLICES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] k_steps,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_left,
  input  logic [7:0] s_top,
  output logic [7:0] arr_left,
  output logic [7:0] arr_top,
  output logic       arr_readout,
  input  logic [7:0] arr_out,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       busy,
  output logic       done
);
  localparam int RESULTS = 2 * SLICES * SLICES;
  localparam int PW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int CW = $clog2(SLICES + 1);
  localparam int RW = $clog2(RESULTS + 1);
  localparam logic [PW-1:0] P_LAST   = PW'(SLICES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SLICES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLICES - 1);
  localparam logic [RW-1:0] RES_N    = RW'(RESULTS);
  localparam logic [RW-1:0] RES_LAST = RW'(RESULTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_FEED, S_EMIT, S_FLUSH, S_READOUT, S_DRAIN
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_p;
  logic [7:0]    r_k_rem;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_buf_left [SLICES];
  logic [7:0]    r_buf_top  [SLICES];
  logic          r_s_ready;
  logic [7:0]    r_arr_left;
  logic [7:0]    r_arr_top;
  logic          r_readout;
  logic          r_done;
  logic [RW-1:0] r_cap;
  logic [RW-1:0] r_out;

  logic          w_accept;
  logic          w_full;
  logic          w_p_last;
  logic [PW-1:0] w_p_inc;
  logic [PW-1:0] w_wr_idx;
  logic [7:0]    w_first_left;
  logic [7:0]    w_first_top;
  logic          w_cap;
  logic          w_m_vld;
  logic [7:0]    w_m_dat;
  logic          w_m_hs;

  assign w_accept = (r_state == S_FEED) && r_s_ready && s_valid;
  assign w_full   = (r_cnt == CNT_FULL) || (w_accept && (r_cnt == CNT_LAST));
  assign w_p_last = (r_p == P_LAST);
  assign w_p_inc  = r_p + PW'(1);
  assign w_wr_idx = r_cnt[PW-1:0];
  // Entry 0 may arrive in the very cycle emission is scheduled (single-slice array).
  assign w_first_left = (w_accept && (r_cnt == '0)) ? s_left : r_buf_left[0];
  assign w_first_top  = (w_accept && (r_cnt == '0)) ? s_top  : r_buf_top[0];
  assign w_cap  = (r_state == S_DRAIN) && (r_cap != RES_N);
  assign w_m_hs = w_m_vld && m_ready;

  fp4_seq_fifo #(.W(8), .DEPTH(RESULTS)) u_res_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_vld (w_cap),
    .i_wr_dat (arr_out),
    .o_rd_vld (w_m_vld),
    .o_rd_dat (w_m_dat),
    .i_rd_rdy (m_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_p        <= '0;
      r_k_rem    <= '0;
      r_cnt      <= '0;
      r_s_ready  <= 1'b0;
      r_arr_left <= '0;
      r_arr_top  <= '0;
      r_readout  <= 1'b0;
      r_done     <= 1'b0;
      r_cap      <= '0;
      r_out      <= '0;
      for (int i = 0; i < SLICES; i++) begin
        r_buf_left[i] <= '0;
        r_buf_top[i]  <= '0;
      end
    end else begin
      r_readout <= 1'b0;
      r_done    <= 1'b0;
      r_p       <= w_p_last ? '0 : w_p_inc;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k_rem   <= k_steps;
            r_readout <= 1'b1;
            r_state   <= S_SYNC;
          end
        end
        S_SYNC: begin
          // The array restarts its slice counter on this pulse; our phase follows it.
          r_p   <= '0;
          r_cnt <= '0;
          if (r_k_rem == 8'd0) begin
            r_state <= S_FLUSH;
          end else begin
            r_state   <= S_FEED;
            r_s_ready <= 1'b1;
          end
        end
        S_FEED: begin
          if (w_accept) begin
            r_buf_left[w_wr_idx] <= s_left;
            r_buf_top[w_wr_idx]  <= s_top;
            r_cnt                <= r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) r_s_ready <= 1'b0;
          end
          if (w_full && w_p_last) begin
            r_state    <= S_EMIT;
            r_s_ready  <= 1'b0;
            r_arr_left <= w_first_left;
            r_arr_top  <= w_first_top;
          end
        end
        S_EMIT: begin
          if (w_p_last) begin
            r_arr_left <= '0;
            r_arr_top  <= '0;
            r_cnt      <= '0;
            r_k_rem    <= r_k_rem - 8'd1;
            if (r_k_rem == 8'd1) begin
              r_state <= S_FLUSH;
            end else begin
              r_state   <= S_FEED;
              r_s_ready <= 1'b1;
            end
          end else begin
            r_arr_left <= r_buf_left[w_p_inc];
            r_arr_top  <= r_buf_top[w_p_inc];
          end
        end
        S_FLUSH: begin
          // Entered on a p==0 cycle; one full period lets the array latch and finish computing.
          if (w_p_last) begin
            r_readout <= 1'b1;
            r_state   <= S_READOUT;
          end
        end
        S_READOUT: begin
          r_cap   <= '0;
          r_out   <= '0;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_cap != RES_N) r_cap <= r_cap + RW'(1);
          if (w_m_hs) begin
            r_out <= r_out + RW'(1);
            if (r_out == RES_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready     = r_s_ready;
  assign arr_left    = r_arr_left;
  assign arr_top     = r_arr_top;
  assign arr_readout = r_readout;
  assign m_valid     = w_m_vld;
  assign m_data      = w_m_dat;
  assign m_last      = w_m_vld && (r_state == S_DRAIN) && (r_out == RES_LAST);
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
endmodule

// File: tb/tb_fp4_array_sequencer.sv
// Bench for fp4_array_sequencer: table of runs plus hand-written reset sequences, with emission and result scoreboards.
module tb_fp4_array_sequencer;
  localparam int SLICES  = 4;
  localparam int RESULTS = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] k_steps = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_left = 8'd0;
  logic [7:0] s_top = 8'd0;
  logic [7:0] arr_left;
  logic [7:0] arr_top;
  logic       arr_readout;
  logic [7:0] arr_out = 8'hEE;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       done;

  fp4_array_sequencer #(.SLICES(SLICES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_steps(k_steps),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_top(s_top),
    .arr_left(arr_left), .arr_top(arr_top), .arr_readout(arr_readout), .arr_out(arr_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  int         t_sync = 0;
  int         ro_q[$];
  logic [15:0] emit_q[$];
  logic [8:0]  res_q[$];
  int emit_first = -1, emit_cnt = 0, misalign = 0;
  int done_cnt = 0, done_cyc = -1, pop_cnt = 0;
  int beat_b = 0;
  bit tog_mode = 1'b0;
  logic [15:0] ev;
  logic [8:0]  rv;

  typedef struct {
    int k;
    int gap;
    bit tog;
    bit extra;
    int exp_emit;
    int exp_ro;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (arr_readout) ro_q.push_back(cyc);
        if (arr_left != 8'd0 || arr_top != 8'd0) begin
          if (emit_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL emit_unexpected: got 0x%0h at cycle %0d expected idle zeros", {arr_left, arr_top}, cyc);
          end else begin
            ev = emit_q.pop_front();
            chk("emit_data", {arr_left, arr_top}, ev);
          end
          if (emit_cnt == 0) emit_first = cyc;
          if (((cyc - t_sync - 1) % SLICES) != (emit_cnt % SLICES)) misalign++;
          emit_cnt++;
        end
        if (m_valid && m_ready) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL result_unexpected: got 0x%0h with no byte outstanding", m_data);
          end else begin
            rv = res_q.pop_front();
            chk("result_data", m_data, rv[7:0]);
            chk("result_last", m_last, rv[8]);
          end
          pop_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // Array stub: after the read-out pulse (not the SYNC pulse) it shifts out 1..RESULTS.
  initial begin
    int  rel;
    bit  is_r;
    bit  busy_prev;
    rel = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      is_r = arr_readout && busy_prev;
      busy_prev = busy;
      @(posedge clk);
      #1;
      if (!rst_n) rel = 0;
      else if (is_r) rel = 1;
      else if (rel != 0) rel++;
      if (rel >= 1 && rel <= RESULTS) begin
        arr_out = 8'(rel);
        res_q.push_back({(rel == RESULTS), 8'(rel)});
      end else begin
        arr_out = 8'hEE;
        rel = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = tog_mode ? ~m_ready : 1'b1;
    end
  end

  task automatic drive_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int w;
      bit ok;
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      s_valid = 1'b1;
      s_left  = 8'(8'h11 * ((beat_b % 15) + 1));
      s_top   = 8'(beat_b + 1);
      ok = 1'b0;
      w  = 0;
      while (!ok && w < 100) begin
        @(negedge clk);
        if (s_ready) begin
          ok = 1'b1;
          emit_q.push_back({s_left, s_top});
        end
        @(posedge clk);
        #1;
        w++;
      end
      s_valid = 1'b0;
      s_left  = 8'd0;
      s_top   = 8'd0;
      beat_b++;
      if (!ok) begin
        chk("beat_accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int n;
    ro_q.delete(); emit_q.delete(); res_q.delete();
    emit_first = -1; emit_cnt = 0; misalign = 0;
    done_cnt = 0; done_cyc = -1; pop_cnt = 0; beat_b = 0;
    tog_mode = v.tog;
    @(posedge clk); #1;
    start = 1'b1; k_steps = 8'(v.k);
    @(posedge clk); #1;
    start = 1'b0; k_steps = 8'd0;
    t_sync = cyc;
    fork
      begin
        if (v.k > 0) begin @(posedge clk); #1; drive_beats(4 * v.k, v.gap); end
      end
      begin
        if (v.extra) begin
          @(posedge clk); #1;
          start = 1'b1; k_steps = 8'd5;
          @(posedge clk); #1;
          start = 1'b0; k_steps = 8'd0;
        end
      end
    join
    n = 0;
    while (done_cnt == 0 && n < 600) begin @(posedge clk); #1; n++; end
    repeat (5) begin @(posedge clk); #1; end
    tog_mode = 1'b0;
    chk($sformatf("v%0d_readout_pulses", id), ro_q.size(), 2);
    if (ro_q.size() >= 1) chk($sformatf("v%0d_sync_cycle", id), ro_q[0] - t_sync, 0);
    if (ro_q.size() >= 2) chk($sformatf("v%0d_readout_cycle", id), ro_q[1] - t_sync, v.exp_ro);
    chk($sformatf("v%0d_emit_count", id), emit_cnt, 4 * v.k);
    if (v.k > 0) chk($sformatf("v%0d_emit_first", id), emit_first - t_sync, v.exp_emit);
    chk($sformatf("v%0d_emit_misaligned", id), misalign, 0);
    chk($sformatf("v%0d_emit_leftover", id), emit_q.size(), 0);
    chk($sformatf("v%0d_result_count", id), pop_cnt, RESULTS);
    chk($sformatf("v%0d_result_leftover", id), res_q.size(), 0);
    chk($sformatf("v%0d_done_pulses", id), done_cnt, 1);
    if (!v.tog && ro_q.size() >= 2)
      chk($sformatf("v%0d_done_cycle", id), done_cyc - ro_q[1], RESULTS + 2);
    chk($sformatf("v%0d_busy_end", id), busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{k: 1, gap: 0, tog: 1'b0, extra: 1'b0, exp_emit: 5,  exp_ro: 13};
    vecs[1] = '{k: 1, gap: 3, tog: 1'b0, extra: 1'b0, exp_emit: 17, exp_ro: 25};
    vecs[2] = '{k: 0, gap: 0, tog: 1'b1, extra: 1'b0, exp_emit: 0,  exp_ro: 5};
    vecs[3] = '{k: 2, gap: 0, tog: 1'b1, extra: 1'b0, exp_emit: 5,  exp_ro: 21};
    vecs[4] = '{k: 3, gap: 1, tog: 1'b0, extra: 1'b0, exp_emit: 9,  exp_ro: 41};
    vecs[5] = '{k: 1, gap: 0, tog: 1'b1, extra: 1'b1, exp_emit: 5,  exp_ro: 13};

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {s_ready, arr_left, arr_top, arr_readout, m_valid, m_data, m_last, busy, done}, 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a FEED cycle.
    @(posedge clk); #1;
    start = 1'b1; k_steps = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; k_steps = 8'd0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_left = 8'h11; s_top = 8'h01;
    @(posedge clk); #1;
    s_left = 8'h22; s_top = 8'h02;
    @(posedge clk); #1;
    s_valid = 1'b0; s_left = 8'd0; s_top = 8'd0;
    chk("busy_in_feed", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {s_ready, arr_left, arr_top, arr_readout, m_valid, m_data, m_last, busy, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset during DRAIN after 10 result bytes.
    ro_q.delete(); emit_q.delete(); res_q.delete();
    pop_cnt = 0; done_cnt = 0; tog_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; k_steps = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    t_sync = cyc;
    n = 0;
    while (pop_cnt < 10 && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_reached_10", pop_cnt, 10);
    chk("drain_fifo_nonempty", m_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("drain_reset_m_valid", m_valid, 1'b0);
    chk("drain_reset_outputs", {s_ready, arr_left, arr_top, arr_readout, m_valid, m_data, m_last, busy, done}, 32'd0);
    @(posedge clk); #1;
    res_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    chk("drain_reset_no_stale", pop_cnt, 10);
    chk("drain_reset_no_done", done_cnt, 0);
    chk("drain_reset_idle", busy, 1'b0);

    run_vec(vecs[0], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
